alu_mc: RTL
===========

# alu_mc

Multi-cycle, width-parametrised ALU with a valid/ready handshake, an iterative barrel-free shifter, and registered flags. It sits between the decode stage and register writeback, and it replaces the single-cycle 8-bit ALU. It keeps the same 4-bit opcode map, adds real carry, borrow and shift-out semantics, and holds a persistent compare flag for branching.

## Interface
- W, 8: operand and result width (≥ 2)
- SW, $clog2(W)+1: width of the internal shift counter (holds 0..W)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  command and operands are valid
- in_ready  out  1  block accepts a command on this edge when high together with in_valid
- alu_cmd  in  4  opcode, see Operation
- inA  in  W  operand A
- inB  in  W  operand B, or shift amount
- sc_i  in  1  carry-in for add and subtract
- out_valid  out  1  result registers hold a completed result
- out_ready  in  1  consumer takes the result on this edge
- rslt  out  W  registered result
- sc_o  out  1  registered carry, borrow or last shifted-out bit
- pari  out  1  registered XOR-reduction of rslt
- one  out  1  registered branch flag, updated by eq/lt only

## Operation
- 0000 add: rslt = A+B+sc_i; sc_o = carry out of bit W-1.
- 0001 sub: rslt = A−B−sc_i; sc_o = borrow.
- 0010 addi: rslt = A+B; sc_o = carry.
- 0011 lb and 0100 sb: rslt = A (address pass-through).
- 0101 movr and 0110 movi: rslt = B.
- 0111 nor, 1000 xor, 1001 and, 1010 or: bitwise operations.
- 1011 sll and 1100 slr: logical shift of A by n = min(B, W) bits, one bit per cycle.
  - sc_o = the last bit shifted out, or 0 if n = 0.
  - If B ≥ W, then rslt = 0.
- 1101 eq and 1110 lt (unsigned): rslt = {0…, cmp}; one = cmp.
- 1111 rxor: rslt = {0…, ^B}.
- For all non-add/sub/shift ops, sc_o = 0.
- pari = ^rslt, computed from the final result.
- one holds its value across all ops except eq/lt.

States:
- IDLE: in_ready = 1.
- SHIFT: acc shifts one bit per edge and cnt decrements. When cnt reaches 1, go to DONE.
- DONE: out_valid = 1.
  - out_ready without in_valid: go to IDLE.
  - out_ready with in_valid: accept the new command directly.

Accepting a command:
- Non-shift op, or shift with n = 0: result registered, go to DONE.
- Shift with n > 0: load acc = A and cnt = n, go to SHIFT.

## Timing
- Reset values: rslt = 0, sc_o = 0, pari = 0, one = 0, out_valid = 0, state IDLE. in_ready is therefore 1.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is 0 throughout SHIFT.
- Latency from the accept edge to out_valid high:
  - non-shift ops: 1 edge;
  - shift ops: 1 + n edges.
- Throughput is one non-shift op per cycle when out_ready is held at 1.
- While out_valid && !out_ready, rslt, sc_o, pari and one are stable.
- Operand inputs are sampled only on the accept edge. Changes at any other time are ignored.
- Reset asserted mid-SHIFT or in DONE: the operation is dropped and all outputs return to their reset values immediately (asynchronous).
- If in_valid is high with in_ready low, nothing is accepted and no state changes.

## Structure
- Package alu_pkg holds:
  - alu_op_e, the 4-bit enum ADD…RXOR;
  - state_e (IDLE, SHIFT, DONE);
  - a function is_shift(op).
- Sub-module alu_core is purely combinational. It is parametrised by W and computes the single-cycle result and carry for every non-shift op.
- alu_mc owns the FSM, the shift accumulator, the counter and the output/flag registers.

## Test plan
- Reset, then add A = 8'hFF, B = 8'h01, sc_i = 1 → after 1 edge: out_valid = 1, rslt = 8'h01, sc_o = 1, pari = 1.
- sll A = 8'b1000_0011, B = 3 → in_ready low for 3 cycles; out_valid on the 4th edge with rslt = 8'b0001_1000 and sc_o = 0. Repeat with B = 9 → rslt = 0 after 9 edges.
- lt A = 5, B = 9 sets one = 1. Then issue xor → one stays 1. Then eq A = 3, B = 4 → one = 0.
- Stream 4 back-to-back or/and ops with out_ready = 1 → 4 results on 4 consecutive edges, no bubbles.
- Hold out_ready = 0 for 5 cycles after a result while changing inA/inB → rslt, sc_o, pari and one are unchanged and no command is accepted.
- Assert reset during the 2nd cycle of slr A = 8'hF0, B = 6 → all outputs return to 0 and in_ready = 1. The next add 2+2 returns 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, FSM states and an
// opcode classification helper used by both the core and the sequencer.
package alu_pkg;

   // 4-bit opcode map, unchanged from the single-cycle ALU it replaces
   typedef enum logic [3:0] {
      ADD  = 4'b0000,
      SUB  = 4'b0001,
      ADDI = 4'b0010,
      LB   = 4'b0011,
      SB   = 4'b0100,
      MOVR = 4'b0101,
      MOVI = 4'b0110,
      NOR  = 4'b0111,
      XOR  = 4'b1000,
      AND  = 4'b1001,
      OR   = 4'b1010,
      SLL  = 4'b1011,
      SLR  = 4'b1100,
      EQ   = 4'b1101,
      LT   = 4'b1110,
      RXOR = 4'b1111
   } alu_op_e;

   // Sequencer states: waiting, iterating a shift, holding a result
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // Shifts are the only opcodes that may take more than one cycle
   function automatic logic is_shift(input alu_op_e op);
      return (op == SLL) || (op == SLR);
   endfunction

   // Compares are the only opcodes that update the branch flag
   function automatic logic is_compare(input alu_op_e op);
      return (op == EQ) || (op == LT);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle datapath of the ALU. Produces result and carry/borrow for
// every opcode that completes in one cycle. For shift opcodes it returns
// the zero-amount result (A unchanged, no shifted-out bit); non-zero
// shifts are iterated by the sequencer in alu_mc.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  alu_op_e        op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           c_in,
   output logic [W-1:0]   res,
   output logic           c_out
);

   // Widened operands so the carry/borrow lands in bit W
   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] c_ext;
   logic [W:0] sum;

   assign a_ext = {1'b0, a};
   assign b_ext = {1'b0, b};
   assign c_ext = {{W{1'b0}}, c_in};

   // Opcode decode into result and carry
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      res   = '0;
      c_out = 1'b0;
      sum   = '0;
      unique case (op)
         ADD: begin
            sum   = a_ext + b_ext + c_ext;
            res   = sum[W-1:0];
            c_out = sum[W];
         end
         SUB: begin
            // Bit W of the widened difference is set exactly when A < B + c_in
            sum   = a_ext - b_ext - c_ext;
            res   = sum[W-1:0];
            c_out = sum[W];
         end
         ADDI: begin
            sum   = a_ext + b_ext;
            res   = sum[W-1:0];
            c_out = sum[W];
         end
         LB, SB:     res = a;
         MOVR, MOVI: res = b;
         NOR:        res = ~(a | b);
         XOR:        res = a ^ b;
         AND:        res = a & b;
         OR:         res = a | b;
         SLL, SLR:   res = a;
         EQ:         res = {{(W-1){1'b0}}, (a == b)};
         LT:         res = {{(W-1){1'b0}}, (a < b)};
         RXOR:       res = {{(W-1){1'b0}}, ^b};
         default: begin
            res   = '0;
            c_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU between decode and writeback. Accepts one command per
// valid/ready handshake, completes non-shift ops in one edge and shifts
// one bit per edge, then holds the result, carry, parity and branch flag
// until the consumer takes them.
module alu_mc
   import alu_pkg::*;
#(
   parameter int W  = 8,
   parameter int SW = $clog2(W) + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     alu_cmd,
   input  logic [W-1:0]   inA,
   input  logic [W-1:0]   inB,
   input  logic           sc_i,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   rslt,
   output logic           sc_o,
   output logic           pari,
   output logic           one
);

   state_e        state;
   alu_op_e       op;
   logic          accept;

   // Shift engine: working value, remaining steps and direction
   logic [W-1:0]  acc;
   logic [SW-1:0] cnt;
   logic          shift_left;
   logic [SW-1:0] shamt;
   logic [W-1:0]  acc_next;
   logic          out_bit;

   // Single-cycle datapath results
   logic [W-1:0]  core_res;
   logic          core_c;

   assign op = alu_op_e'(alu_cmd);

   // A new command may enter when idle, or when the held result is being
   // taken on this same edge (keeps back-to-back throughput at one per cycle)
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Amounts of W or more saturate to W, which clears the value anyway
   assign shamt = (inB >= W'(W)) ? SW'(W) : SW'(inB);

   // One shift step and the bit it pushes out
   assign acc_next = shift_left ? {acc[W-2:0], 1'b0} : {1'b0, acc[W-1:1]};
   assign out_bit  = shift_left ? acc[W-1] : acc[0];

   alu_core #(
      .W (W)
   ) u_core (
      .op    (op),
      .a     (inA),
      .b     (inB),
      .c_in  (sc_i),
      .res   (core_res),
      .c_out (core_c)
   );

   // Sequencer: accepts commands, iterates shifts and owns all output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         rslt       <= '0;
         sc_o       <= 1'b0;
         pari       <= 1'b0;
         one        <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         shift_left <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (is_shift(op) && (shamt != '0)) begin
                     acc        <= inA;
                     cnt        <= shamt;
                     shift_left <= (op == SLL);
                     out_valid  <= 1'b0;
                     state      <= SHIFT;
                  end else begin
                     rslt      <= core_res;
                     sc_o      <= core_c;
                     pari      <= ^core_res;
                     if (is_compare(op)) begin
                        one <= core_res[0];
                     end
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else if ((state == DONE) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            SHIFT: begin
               acc <= acc_next;
               cnt <= cnt - 1'b1;
               // Last step publishes the shifted value and its final carry-out
               if (cnt == SW'(1)) begin
                  rslt      <= acc_next;
                  sc_o      <= out_bit;
                  pari      <= ^acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
